// File: rtl/doodle_game_ctrl.sv
// Game sequencer for the doodle datapath: IDLE/PLAY/FALL/OVER, scroll trigger, scoring.
// Optional feature macro HIGH_SCORE_EN: high_score output plus +1 score per bounce.
module doodle_game_ctrl #(
  parameter int unsigned EARTH         = 700,
  parameter int unsigned SCROLL_LINE   = 200,
  parameter int unsigned SCROLL_FRAMES = 16,
  parameter int unsigned SCROLL_STEP   = 12,
  parameter int unsigned FALL_FRAMES   = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic        i_start_btn,
  input  logic [9:0]  i_doodle_y,
  input  logic        i_doodle_fall_direction,
  input  logic        i_collision,
  output logic [1:0]  o_game_state,
  output logic        o_move_collision,
  output logic        o_scroll_active,
  output logic [9:0]  o_scroll_offset,
  output logic [15:0] o_score,
  output logic        o_game_rst
`ifdef HIGH_SCORE_EN
  , output logic [15:0] o_high_score
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_FALL = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam logic [9:0]  L_EARTH         = 10'(EARTH);
  localparam logic [9:0]  L_SCROLL_LINE   = 10'(SCROLL_LINE);
  localparam logic [7:0]  L_SCROLL_FRAMES = 8'(SCROLL_FRAMES);
  localparam logic [7:0]  L_FALL_FRAMES   = 8'(FALL_FRAMES);
  localparam logic [15:0] L_STEP16        = 16'(SCROLL_STEP);
  localparam logic [9:0]  L_STEP10        = 10'(SCROLL_STEP);

  state_t      r_state;
  logic        r_start_prev;
  logic        r_start_pend;
  logic        r_scroll_active;
  logic [7:0]  r_scroll_cnt;
  logic [7:0]  r_fall_cnt;
  logic [9:0]  r_scroll_offset;
  logic [15:0] r_score;
`ifdef HIGH_SCORE_EN
  logic [15:0] r_high_score;
`endif

  logic        w_start_rise;
  logic        w_pend;
  logic        w_fall_hit;
  logic        w_scroll_hit;
  logic        w_play_tick;
  logic        w_trigger;
  logic        w_scroll_frame;
  logic        w_begin;
  logic        w_bonus;
  logic [16:0] w_score_sum;
  logic [15:0] w_score_next;

`ifndef HIGH_SCORE_EN
  logic w_unused_collision;
  assign w_unused_collision = i_collision;
`endif

  // Per-tick decisions; the r_scroll_cnt counter is only meaningful while scroll is active.
  always_comb begin
    w_start_rise   = i_start_btn & ~r_start_prev;
    w_pend         = r_start_pend | w_start_rise;
    w_fall_hit     = i_doodle_fall_direction && (i_doodle_y >= L_EARTH);
    w_scroll_hit   = !r_scroll_active && (i_doodle_y < L_SCROLL_LINE);
    w_play_tick    = i_frame_tick && (r_state == S_PLAY);
    w_trigger      = w_play_tick && !w_fall_hit && w_scroll_hit;
    w_scroll_frame = w_play_tick && !w_fall_hit && (w_scroll_hit || r_scroll_active);
    w_begin        = i_frame_tick && (r_state == S_IDLE) && w_pend;
`ifdef HIGH_SCORE_EN
    w_bonus        = w_play_tick && i_collision && i_doodle_fall_direction;
`else
    w_bonus        = 1'b0;
`endif
    w_score_sum    = {1'b0, r_score}
                   + {1'b0, (w_scroll_frame ? L_STEP16 : 16'd0)}
                   + {16'd0, w_bonus};
    if (w_score_sum[16]) begin
      w_score_next = 16'hFFFF;
    end else begin
      w_score_next = w_score_sum[15:0];
    end
  end

  // Game sequencer, scroll/fall counters, score and start-button history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_start_prev    <= 1'b0;
      r_start_pend    <= 1'b0;
      r_scroll_active <= 1'b0;
      r_scroll_cnt    <= 8'd0;
      r_fall_cnt      <= 8'd0;
      r_scroll_offset <= 10'd0;
      r_score         <= 16'd0;
`ifdef HIGH_SCORE_EN
      r_high_score    <= 16'd0;
`endif
    end else begin
      r_start_prev <= i_start_btn;
      // A tick always consumes the pending start; FALL discards presses outright.
      if ((r_state == S_FALL) || i_frame_tick) begin
        r_start_pend <= 1'b0;
      end else if (w_start_rise) begin
        r_start_pend <= 1'b1;
      end

      if (i_frame_tick) begin
        case (r_state)
          S_IDLE: begin
            if (w_pend) begin
              r_state         <= S_PLAY;
              r_score         <= 16'd0;
              r_scroll_offset <= 10'd0;
              r_scroll_active <= 1'b0;
              r_scroll_cnt    <= 8'd0;
              r_fall_cnt      <= 8'd0;
            end
          end
          S_PLAY: begin
            r_score <= w_score_next;
            if (w_fall_hit) begin
              r_state         <= S_FALL;
              r_fall_cnt      <= L_FALL_FRAMES;
              r_scroll_active <= 1'b0;
              r_scroll_cnt    <= 8'd0;
            end else if (w_scroll_frame) begin
              r_scroll_offset <= r_scroll_offset + L_STEP10;
              // The trigger tick is itself the first scroll frame.
              if (w_trigger) begin
                r_scroll_cnt    <= L_SCROLL_FRAMES - 8'd1;
                r_scroll_active <= (L_SCROLL_FRAMES != 8'd1);
              end else begin
                r_scroll_cnt    <= r_scroll_cnt - 8'd1;
                r_scroll_active <= (r_scroll_cnt != 8'd1);
              end
            end
          end
          S_FALL: begin
            if (r_fall_cnt <= 8'd1) begin
              r_state    <= S_OVER;
              r_fall_cnt <= 8'd0;
`ifdef HIGH_SCORE_EN
              if (r_score > r_high_score) begin
                r_high_score <= r_score;
              end
`endif
            end else begin
              r_fall_cnt <= r_fall_cnt - 8'd1;
            end
          end
          S_OVER: begin
            if (w_pend) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_game_state     = r_state;
  assign o_move_collision = w_trigger;
  assign o_game_rst       = w_begin;
  assign o_scroll_active  = r_scroll_active;
  assign o_scroll_offset  = r_scroll_offset;
  assign o_score          = r_score;
`ifdef HIGH_SCORE_EN
  assign o_high_score     = r_high_score;
`endif

endmodule

// File: tb/tb_doodle_game_ctrl.sv
// Directed self-checking bench for doodle_game_ctrl (frame tick every other clock).
module tb_doodle_game_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        start_btn;
  logic [9:0]  doodle_y;
  logic        fall_dir;
  logic        collision;
  logic [1:0]  game_state;
  logic        move_collision;
  logic        scroll_active;
  logic [9:0]  scroll_offset;
  logic [15:0] score;
  logic        game_rst;
`ifdef HIGH_SCORE_EN
  logic [15:0] high_score;
`endif

  int   n_vec;
  int   n_err;
  logic last_mc;
  logic last_gr;

  doodle_game_ctrl dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_frame_tick            (frame_tick),
    .i_start_btn             (start_btn),
    .i_doodle_y              (doodle_y),
    .i_doodle_fall_direction (fall_dir),
    .i_collision             (collision),
    .o_game_state            (game_state),
    .o_move_collision        (move_collision),
    .o_scroll_active         (scroll_active),
    .o_scroll_offset         (scroll_offset),
    .o_score                 (score),
    .o_game_rst              (game_rst)
`ifdef HIGH_SCORE_EN
    , .o_high_score          (high_score)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame tick: pulses are captured mid-tick, registered state is visible on return.
  task automatic do_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    #1;
    last_mc = move_collision;
    last_gr = game_rst;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic press();
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    // Only a formatting shim; every caller performs its own comparison below.
    $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_vec++; if (game_state !== 2'd0) begin n_err++; chk("rst_state", game_state, 0); end
    n_vec++; if (move_collision !== 1'b0) begin n_err++; chk("rst_mc", move_collision, 0); end
    n_vec++; if (scroll_active !== 1'b0) begin n_err++; chk("rst_active", scroll_active, 0); end
    n_vec++; if (scroll_offset !== 10'd0) begin n_err++; chk("rst_offset", scroll_offset, 0); end
    n_vec++; if (score !== 16'd0) begin n_err++; chk("rst_score", score, 0); end
    n_vec++; if (game_rst !== 1'b0) begin n_err++; chk("rst_game_rst", game_rst, 0); end
`ifdef HIGH_SCORE_EN
    n_vec++; if (high_score !== 16'd0) begin n_err++; chk("rst_high", high_score, 0); end
`endif
  endtask

  task automatic test_start();
    doodle_y = 10'd400;
    fall_dir = 1'b0;
    do_tick();
    n_vec++; if (game_state !== 2'd0) begin n_err++; chk("idle_no_press", game_state, 0); end
    press();
    n_vec++; if (game_state !== 2'd0) begin n_err++; chk("pend_wait_tick", game_state, 0); end
    do_tick();
    n_vec++; if (last_gr !== 1'b1) begin n_err++; chk("start_game_rst", last_gr, 1); end
    n_vec++; if (game_state !== 2'd1) begin n_err++; chk("start_state", game_state, 1); end
    n_vec++; if (game_rst !== 1'b0) begin n_err++; chk("game_rst_width", game_rst, 0); end
    n_vec++; if (score !== 16'd0) begin n_err++; chk("start_score", score, 0); end
    do_tick();
    n_vec++; if (last_mc !== 1'b0) begin n_err++; chk("no_scroll_y400", last_mc, 0); end
    n_vec++; if (scroll_active !== 1'b0) begin n_err++; chk("idle_scroll_y400", scroll_active, 0); end
  endtask

  task automatic test_scroll();
    doodle_y = 10'd150;
    for (int i = 1; i <= 17; i++) begin
      do_tick();
      if (i == 1) begin
        n_vec++; if (last_mc !== 1'b1) begin n_err++; chk("trig_mc", last_mc, 1); end
        n_vec++; if (scroll_active !== 1'b1) begin n_err++; chk("trig_active", scroll_active, 1); end
        n_vec++; if (scroll_offset !== 10'd12) begin n_err++; chk("trig_offset", scroll_offset, 12); end
      end else if (i <= 16) begin
        n_vec++; if (last_mc !== 1'b0) begin n_err++; chk("no_retrigger", last_mc, 0); end
      end else begin
        n_vec++; if (last_mc !== 1'b1) begin n_err++; chk("retrigger_17", last_mc, 1); end
      end
      if (i == 15) begin
        n_vec++; if (scroll_active !== 1'b1) begin n_err++; chk("active_15", scroll_active, 1); end
      end
      if (i == 16) begin
        n_vec++; if (scroll_active !== 1'b0) begin n_err++; chk("active_drop_16", scroll_active, 0); end
        n_vec++; if (scroll_offset !== 10'd192) begin n_err++; chk("offset_192", scroll_offset, 192); end
        n_vec++; if (score !== 16'd192) begin n_err++; chk("score_192", score, 192); end
      end
    end
    n_vec++; if (score !== 16'd204) begin n_err++; chk("score_204", score, 204); end
  endtask

  task automatic test_fall_over();
    fall_dir = 1'b1;
    do_tick();
    n_vec++; if (scroll_offset !== 10'd216) begin n_err++; chk("fall_dir_scroll", scroll_offset, 216); end
    n_vec++; if (game_state !== 2'd1) begin n_err++; chk("above_earth_play", game_state, 1); end
    doodle_y = 10'd710;
    do_tick();
    n_vec++; if (game_state !== 2'd2) begin n_err++; chk("enter_fall", game_state, 2); end
    n_vec++; if (scroll_active !== 1'b0) begin n_err++; chk("fall_cancel", scroll_active, 0); end
    n_vec++; if (last_mc !== 1'b0) begin n_err++; chk("fall_mc", last_mc, 0); end
    n_vec++; if (scroll_offset !== 10'd216) begin n_err++; chk("fall_offset", scroll_offset, 216); end
    n_vec++; if (score !== 16'd216) begin n_err++; chk("fall_score", score, 216); end
    for (int i = 1; i <= 60; i++) begin
      do_tick();
      if (i == 30) press();
      if (i == 59) begin
        n_vec++; if (game_state !== 2'd2) begin n_err++; chk("fall_59", game_state, 2); end
      end
    end
    n_vec++; if (game_state !== 2'd3) begin n_err++; chk("over_60", game_state, 3); end
    do_tick();
    n_vec++; if (game_state !== 2'd3) begin n_err++; chk("fall_press_ignored", game_state, 3); end
    press();
    do_tick();
    n_vec++; if (game_state !== 2'd0) begin n_err++; chk("over_to_idle", game_state, 0); end
    n_vec++; if (last_gr !== 1'b0) begin n_err++; chk("over_no_game_rst", last_gr, 0); end
    n_vec++; if (score !== 16'd216) begin n_err++; chk("idle_score_held", score, 216); end
    doodle_y = 10'd400;
    fall_dir = 1'b0;
    press();
    do_tick();
    n_vec++; if (game_state !== 2'd1) begin n_err++; chk("restart_play", game_state, 1); end
    n_vec++; if (last_gr !== 1'b1) begin n_err++; chk("restart_game_rst", last_gr, 1); end
    n_vec++; if (score !== 16'd0) begin n_err++; chk("restart_score", score, 0); end
    n_vec++; if (scroll_offset !== 10'd0) begin n_err++; chk("restart_offset", scroll_offset, 0); end
  endtask

  task automatic test_saturation();
    doodle_y = 10'd150;
    for (int i = 1; i <= 5463; i++) begin
      do_tick();
      if (i == 5461) begin
        n_vec++; if (score !== 16'd65532) begin n_err++; chk("score_65532", score, 65532); end
        n_vec++; if (scroll_offset !== 10'd1020) begin n_err++; chk("offset_1020", scroll_offset, 1020); end
      end
      if (i == 5462) begin
        n_vec++; if (score !== 16'hFFFF) begin n_err++; chk("score_sat", score, 65535); end
      end
    end
    n_vec++; if (score !== 16'hFFFF) begin n_err++; chk("score_sat_hold", score, 65535); end
    n_vec++; if (scroll_offset !== 10'd20) begin n_err++; chk("offset_wrap", scroll_offset, 20); end
  endtask

  task automatic test_reset_mid_scroll();
    n_vec++; if (scroll_active !== 1'b1) begin n_err++; chk("pre_rst_active", scroll_active, 1); end
    press();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (game_state !== 2'd0) begin n_err++; chk("midrst_state", game_state, 0); end
    n_vec++; if (scroll_active !== 1'b0) begin n_err++; chk("midrst_active", scroll_active, 0); end
    n_vec++; if (scroll_offset !== 10'd0) begin n_err++; chk("midrst_offset", scroll_offset, 0); end
    n_vec++; if (score !== 16'd0) begin n_err++; chk("midrst_score", score, 0); end
    n_vec++; if (move_collision !== 1'b0) begin n_err++; chk("midrst_mc", move_collision, 0); end
    n_vec++; if (game_rst !== 1'b0) begin n_err++; chk("midrst_game_rst", game_rst, 0); end
    rst = 1'b0;
    do_tick();
    n_vec++; if (game_state !== 2'd0) begin n_err++; chk("rst_clears_pending", game_state, 0); end
  endtask

`ifdef HIGH_SCORE_EN
  task automatic play_game(input int frames);
    doodle_y = 10'd400;
    fall_dir = 1'b0;
    press();
    do_tick();
    doodle_y = 10'd150;
    repeat (frames) do_tick();
    doodle_y = 10'd710;
    fall_dir = 1'b1;
    do_tick();
    repeat (60) do_tick();
    press();
    do_tick();
  endtask

  task automatic test_high_score();
    play_game(25);
    n_vec++; if (high_score !== 16'd300) begin n_err++; chk("high_game1", high_score, 300); end
    play_game(10);
    n_vec++; if (score !== 16'd120) begin n_err++; chk("game2_score", score, 120); end
    n_vec++; if (high_score !== 16'd300) begin n_err++; chk("high_kept", high_score, 300); end
    doodle_y = 10'd400;
    fall_dir = 1'b0;
    press();
    do_tick();
    n_vec++; if (high_score !== 16'd300) begin n_err++; chk("high_after_rst", high_score, 300); end
    collision = 1'b1;
    fall_dir = 1'b1;
    do_tick();
    collision = 1'b0;
    n_vec++; if (score !== 16'd1) begin n_err++; chk("bounce_bonus", score, 1); end
  endtask
`endif

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    doodle_y   = 10'd400;
    fall_dir   = 1'b0;
    collision  = 1'b0;
    last_mc    = 1'b0;
    last_gr    = 1'b0;
    test_reset();
    test_start();
    test_scroll();
    test_fall_over();
    test_saturation();
    test_reset_mid_scroll();
`ifdef HIGH_SCORE_EN
    test_high_score();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
